// File: rtl/adsr_envelope.sv
// Gated ADSR amplitude envelope applied to the DDS sine stream.
// Envelope level steps once per prescaler tick; the sample path is a 2-stage registered multiply.
module adsr_envelope #(
  parameter int unsigned TICK_DIV    = 1024,
  parameter int unsigned LEVEL_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_active_high,
  input  logic                   gate,
  input  logic [LEVEL_WIDTH-1:0] attack_rate,
  input  logic [LEVEL_WIDTH-1:0] decay_rate,
  input  logic [LEVEL_WIDTH-1:0] sustain_level,
  input  logic [LEVEL_WIDTH-1:0] release_rate,
  input  logic [15:0]            sample_in,
  output logic [15:0]            audio_out,
  output logic [LEVEL_WIDTH-1:0] env_level,
  output logic [2:0]             env_state,
  output logic                   active
);

  localparam int unsigned CntW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PW   = LEVEL_WIDTH + 17;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  state_e                 r_state, w_state_d;
  logic [LEVEL_WIDTH-1:0] r_level, w_level_d;
  logic [CntW-1:0]        r_cnt;
  logic                   r_gate_prev;
  logic                   r_after_rst;
  logic signed [PW-1:0]   r_prod;
  logic [15:0]            r_audio;

  logic                   w_tick, w_rise, w_fall;
  logic [LEVEL_WIDTH:0]   w_sum, w_floor;
  logic signed [PW-1:0]   w_samp_ext, w_lvl_ext, w_prod;

  assign w_tick = (r_cnt == CntW'(TICK_DIV - 1));
  // Edges are masked for one cycle after reset so a gate held through reset does not retrigger.
  assign w_rise = gate & ~r_gate_prev & ~r_after_rst;
  assign w_fall = ~gate & r_gate_prev & ~r_after_rst;

  assign w_sum   = {1'b0, r_level} + {1'b0, attack_rate};
  assign w_floor = {1'b0, sustain_level} + {1'b0, decay_rate};

  always_comb begin
    w_state_d = r_state;
    w_level_d = r_level;
    if (w_rise) begin
      w_state_d = StAttack;
    end else if (w_fall && (r_state == StAttack || r_state == StDecay ||
                            r_state == StSustain)) begin
      w_state_d = StRelease;
    end else if (w_tick) begin
      case (r_state)
        StAttack: begin
          if (w_sum >= {1'b0, {LEVEL_WIDTH{1'b1}}}) begin
            w_level_d = {LEVEL_WIDTH{1'b1}};
            w_state_d = StDecay;
          end else begin
            w_level_d = w_sum[LEVEL_WIDTH-1:0];
          end
        end
        StDecay: begin
          if ({1'b0, r_level} <= w_floor) begin
            w_level_d = sustain_level;
            w_state_d = StSustain;
          end else begin
            w_level_d = r_level - decay_rate;
          end
        end
        StSustain: w_level_d = sustain_level;
        StRelease: begin
          if (r_level <= release_rate) begin
            w_level_d = '0;
            w_state_d = StIdle;
          end else begin
            w_level_d = r_level - release_rate;
          end
        end
        default: w_level_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      r_state     <= StIdle;
      r_level     <= '0;
      r_cnt       <= '0;
      r_gate_prev <= 1'b0;
      r_after_rst <= 1'b1;
    end else begin
      r_state     <= w_state_d;
      r_level     <= w_level_d;
      r_cnt       <= w_tick ? '0 : r_cnt + CntW'(1);
      r_gate_prev <= gate;
      r_after_rst <= 1'b0;
    end
  end

  // Level is zero-extended so the product is a signed-by-unsigned multiply.
  assign w_samp_ext = PW'($signed(sample_in));
  assign w_lvl_ext  = PW'({1'b0, r_level});
  assign w_prod     = w_samp_ext * w_lvl_ext;

  always_ff @(posedge clk) begin
    if (rst_active_high) begin
      r_prod  <= '0;
      r_audio <= '0;
    end else begin
      r_prod  <= w_prod;
      r_audio <= r_prod[LEVEL_WIDTH+15:LEVEL_WIDTH];
    end
  end

  assign audio_out = r_audio;
  assign env_level = r_level;
  assign env_state = r_state;
  assign active    = (r_state != StIdle);

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope: directed envelope scenarios followed by random traffic,
// checked against an arithmetic reference model of the envelope and multiply.
module tb_adsr_envelope;

  localparam int unsigned TickDiv = 4;

  logic               clk;
  logic               rst;
  logic               gate;
  logic [15:0]        ar, dr, sus, rr;
  logic signed [15:0] samp;
  logic [15:0]        audio_out, env_level;
  logic [2:0]         env_state;
  logic               active;

  adsr_envelope #(
    .TICK_DIV    (TickDiv),
    .LEVEL_WIDTH (16)
  ) dut (
    .clk             (clk),
    .rst_active_high (rst),
    .gate            (gate),
    .attack_rate     (ar),
    .decay_rate      (dr),
    .sustain_level   (sus),
    .release_rate    (rr),
    .sample_in       (samp),
    .audio_out       (audio_out),
    .env_level       (env_level),
    .env_state       (env_state),
    .active          (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int st;
    int lvl;
    int aud;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state, describing the DUT as seen after the most recent edge.
  int     m_state = 0, m_level = 0, m_cnt = 0, m_audio = 0;
  bit     m_prev = 0, m_mask = 1;
  longint m_p = 0;

  task automatic model_step();
    exp_t e;
    bit   tick, rise, fall;
    int   s;
    if (rst) begin
      m_state = 0; m_level = 0; m_cnt = 0; m_prev = 0; m_mask = 1; m_p = 0; m_audio = 0;
    end else begin
      tick    = (m_cnt == TickDiv - 1);
      m_cnt   = tick ? 0 : m_cnt + 1;
      m_audio = int'(m_p >>> 16);
      s       = samp;
      m_p     = longint'(s) * longint'(m_level);
      rise    = !m_mask && gate && !m_prev;
      fall    = !m_mask && !gate && m_prev;
      if (rise) m_state = 1;
      else if (fall && m_state >= 1 && m_state <= 3) m_state = 4;
      else if (tick) begin
        case (m_state)
          1: if (m_level + int'(ar) >= 65535) begin m_level = 65535; m_state = 2; end
             else m_level = m_level + int'(ar);
          2: if (m_level <= int'(sus) + int'(dr)) begin m_level = int'(sus); m_state = 3; end
             else m_level = m_level - int'(dr);
          3: m_level = int'(sus);
          4: if (m_level <= int'(rr)) begin m_level = 0; m_state = 0; end
             else m_level = m_level - int'(rr);
          default: m_level = 0;
        endcase
      end
      m_prev = gate;
      m_mask = 0;
    end
    e.st = m_state; e.lvl = m_level; e.aud = m_audio;
    q.push_back(e);
  endtask

  // Called at a negedge with inputs already set; returns at the following negedge.
  task automatic cyc();
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      samp = 16'($urandom);
      cyc();
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("env_state", int'(env_state), e.st);
        check("env_level", int'(env_level), e.lvl);
        check("audio_out", int'($signed(audio_out)), e.aud);
        check("active", int'(active), int'(e.st != 0));
      end
    end
  end

  initial begin : driver
    int budget;
    bit hold_low;
    rst = 1; gate = 0; ar = 16'h4000; dr = 16'h1000; sus = 16'hC000; rr = 16'h8000; samp = 0;
    run(3);
    rst = 0;
    run(3);

    // Attack to full scale, decay to sustain, then live sustain changes.
    gate = 1;
    run(40);
    sus = 16'hA000;
    run(8);
    sus = 16'hC000;
    run(8);

    // Release, retriggering at 0x4000 on a tick cycle.
    gate = 0;
    budget = 0;
    while (!(m_state == 4 && m_level == 16'h4000 && m_cnt == TickDiv - 1) && budget < 50) begin
      run(1);
      budget++;
    end
    check("retrigger_reached", int'(budget < 50), 1);
    gate = 1;
    run(12);

    // Hold full scale in DECAY with a zero decay rate, then exercise the datapath.
    ar = 16'hFFFF; dr = 16'h0000; gate = 0;
    run(12);
    gate = 1;
    run(8);
    samp = 16384;   cyc();
    samp = -32768;  cyc();
    run(4);
    sus = 16'h8000; dr = 16'hFFFF;
    run(8);
    samp = -1000;   cyc();
    cyc();
    run(4);

    // Reset mid-note in DECAY with the gate held high.
    ar = 16'hFFFF; dr = 16'h0100; sus = 16'h2000; gate = 0;
    run(8);
    gate = 1;
    run(9);
    rst = 1; run(1);
    rst = 0; run(10);
    gate = 0; run(3);
    gate = 1; run(12);

    // Random traffic.
    hold_low = 0;
    for (int blk = 0; blk < 15; blk++) begin
      ar  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h4000));
      dr  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
      rr  = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h3000));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 60) == 0) sus = 16'($urandom);
        if (hold_low) hold_low = 0;
        else if ($urandom_range(0, 30) == 0) gate = ~gate;
        rst = (!gate && !hold_low && $urandom_range(0, 400) == 0);
        if (rst) hold_low = 1;
        run(1);
      end
      rst = 0;
    end

    rst = 0;
    run(4);
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
